// File: rtl/ex_fwd_pkg.sv
// Shared types and helpers for the EX-stage forwarding unit.
// Entry payload (rw/data) lives in parallel arrays sized by module parameters.
package ex_fwd_pkg;

    typedef struct packed {
        logic valid;
        logic regwrite;
        logic is_load;
        logic ready;
    } fwd_entry_t;

    localparam int DEF_DEPTH = 2;
    localparam int STG_IDX_W = $clog2(DEF_DEPTH + 1);

    // Width needed to number stages 1..depth with 0 meaning "no stage".
    function automatic int stg_idx_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ex_fwd_unit_if.sv
// EX-stage operand/forwarding bus between the pipeline datapath (master)
// and the forwarding unit (slave).
interface ex_fwd_unit_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int NSRC   = 2
);
    logic                     ex_valid;
    logic                     ex_regwrite;
    logic                     ex_is_load;
    logic [REG_AW-1:0]        ex_rw;
    logic [DATA_W-1:0]        ex_alu_result;
    logic [NSRC*REG_AW-1:0]   ex_src_addr;
    logic [NSRC*DATA_W-1:0]   ex_src_rf;
    logic [DATA_W-1:0]        mem_load_data;

    logic [NSRC*DATA_W-1:0]   ex_opnd;
    logic [NSRC-1:0]          ex_fwd_hit;
    logic                     stall;
    logic                     wb_we;
    logic [REG_AW-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;

    modport master (
        output ex_valid, ex_regwrite, ex_is_load, ex_rw, ex_alu_result,
               ex_src_addr, ex_src_rf, mem_load_data,
        input  ex_opnd, ex_fwd_hit, stall, wb_we, wb_addr, wb_data
    );

    modport slave (
        input  ex_valid, ex_regwrite, ex_is_load, ex_rw, ex_alu_result,
               ex_src_addr, ex_src_rf, mem_load_data,
        output ex_opnd, ex_fwd_hit, stall, wb_we, wb_addr, wb_data
    );

endinterface

// File: rtl/ex_fwd_chan.sv
// One operand channel: priority match over the in-flight stages, youngest
// (lowest-numbered) stage wins; an unready winner raises a stall request.
module ex_fwd_chan
    import ex_fwd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2
) (
    input  logic [REG_AW-1:0] src_addr,
    input  logic [DATA_W-1:0] src_rf,
    input  fwd_entry_t        ent      [DEPTH],
    input  logic [REG_AW-1:0] ent_rw   [DEPTH],
    input  logic [DATA_W-1:0] ent_data [DEPTH],
    output logic [DATA_W-1:0] opnd,
    output logic              hit,
    output logic              stall_req
);

    localparam int IDX_W = stg_idx_w(DEPTH);

    logic [DEPTH-1:0] match;
    logic [IDX_W-1:0] win;    // winning stage number, 0 when nothing matches

    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            match[s] = ent[s].valid && ent[s].regwrite &&
                       (ent_rw[s] == src_addr) && (src_addr != '0);
        end
    end

    always_comb begin
        win = '0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (match[s]) win = IDX_W'(s + 1);
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        opnd      = src_rf;
        hit       = 1'b0;
        stall_req = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            if (win == IDX_W'(s + 1)) begin
                if (ent[s].ready) begin
                    opnd = ent_data[s];
                    hit  = 1'b1;
                end else begin
                    stall_req = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ex_fwd_unit.sv
// EX-stage forwarding and result-tracking unit: DEPTH-stage result pipeline,
// youngest-match forwarding, load-use stall, writeback from the last stage.
// Optional EX_FWD_STALL_CNT_EN adds a 32-bit stall_cnt output.
module ex_fwd_unit
    import ex_fwd_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int NSRC       = 2,
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 1
) (
    input  logic          clk,
    input  logic          rst,
    ex_fwd_unit_if.slave  bus
`ifdef EX_FWD_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    fwd_entry_t        ent      [DEPTH];
    fwd_entry_t        ent_nxt  [DEPTH];
    logic [REG_AW-1:0] rw_q     [DEPTH];
    logic [REG_AW-1:0] rw_nxt   [DEPTH];
    logic [DATA_W-1:0] data_q   [DEPTH];
    logic [DATA_W-1:0] data_nxt [DEPTH];

    logic [NSRC-1:0]   stall_req;
    logic              admit;

    assign bus.stall = bus.ex_valid & (|stall_req);
    assign admit     = bus.ex_valid & ~bus.stall;

    always_comb begin
        ent_nxt[0]  = '0;
        rw_nxt[0]   = '0;
        data_nxt[0] = '0;
        if (admit) begin
            ent_nxt[0].valid    = 1'b1;
            ent_nxt[0].regwrite = bus.ex_regwrite;
            ent_nxt[0].is_load  = bus.ex_is_load;
            ent_nxt[0].ready    = ~bus.ex_is_load;
            rw_nxt[0]           = bus.ex_rw;
            data_nxt[0]         = bus.ex_is_load ? '0 : bus.ex_alu_result;
        end
        // Older stages shift every cycle; a stall only bubbles stage 1.
        for (int s = 1; s < DEPTH; s++) begin
            ent_nxt[s]  = ent[s-1];
            rw_nxt[s]   = rw_q[s-1];
            data_nxt[s] = data_q[s-1];
            if (s == LOAD_STAGE && ent[s-1].valid && ent[s-1].is_load) begin
                ent_nxt[s].ready = 1'b1;
                data_nxt[s]      = bus.mem_load_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent         <= '{default: '0};
            bus.wb_we   <= 1'b0;
            bus.wb_addr <= '0;
            bus.wb_data <= '0;
        end else begin
            // NOTE: non-blocking so each stage takes its neighbour's pre-edge value.
            ent         <= ent_nxt;
            bus.wb_we   <= ent_nxt[DEPTH-1].valid & ent_nxt[DEPTH-1].regwrite &
                           (rw_nxt[DEPTH-1] != '0);
            bus.wb_addr <= rw_nxt[DEPTH-1];
            bus.wb_data <= data_nxt[DEPTH-1];
        end
    end

    // NOTE: payload arrays carry no reset; every consumer is gated by the reset valid flag.
    always_ff @(posedge clk) begin
        rw_q   <= rw_nxt;
        data_q <= data_nxt;
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_chan
        ex_fwd_chan #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW),
            .DEPTH  (DEPTH)
        ) u_chan (
            .src_addr  (bus.ex_src_addr[i*REG_AW +: REG_AW]),
            .src_rf    (bus.ex_src_rf[i*DATA_W +: DATA_W]),
            .ent       (ent),
            .ent_rw    (rw_q),
            .ent_data  (data_q),
            .opnd      (bus.ex_opnd[i*DATA_W +: DATA_W]),
            .hit       (bus.ex_fwd_hit[i]),
            .stall_req (stall_req[i])
        );
    end

`ifdef EX_FWD_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (bus.stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_fwd_unit.sv
// Bench for ex_fwd_unit: directed cycle table, reset/stall-count sequences,
// and random traffic against an age-based reference model.
module tb_ex_fwd_unit;

    localparam int DATA_W     = 32;
    localparam int REG_AW     = 5;
    localparam int NSRC       = 2;
    localparam int DEPTH      = 2;
    localparam int LOAD_STAGE = 1;

    logic clk;
    logic rst;
`ifdef EX_FWD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    ex_fwd_unit_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NSRC(NSRC)) bus ();

    ex_fwd_unit #(
        .DATA_W     (DATA_W),
        .REG_AW     (REG_AW),
        .NSRC       (NSRC),
        .DEPTH      (DEPTH),
        .LOAD_STAGE (LOAD_STAGE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef EX_FWD_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Current EX-side stimulus
    bit          cur_v, cur_rg, cur_ld;
    logic [4:0]  cur_rw;
    logic [31:0] cur_alu, cur_mld;
    logic [4:0]  cur_src [NSRC];
    logic [31:0] cur_rf  [NSRC];

    task automatic apply_cur();
        bus.ex_valid      = cur_v;
        bus.ex_regwrite   = cur_rg;
        bus.ex_is_load    = cur_ld;
        bus.ex_rw         = cur_rw;
        bus.ex_alu_result = cur_alu;
        bus.mem_load_data = cur_mld;
        for (int i = 0; i < NSRC; i++) begin
            bus.ex_src_addr[i*REG_AW +: REG_AW] = cur_src[i];
            bus.ex_src_rf[i*DATA_W +: DATA_W]   = cur_rf[i];
        end
    endtask

    task automatic set_in(input bit v, rg, ld, input logic [4:0] rw, input logic [31:0] alu,
                          input logic [4:0] s0, s1, input logic [31:0] rf0, rf1, mld);
        cur_v = v; cur_rg = rg; cur_ld = ld; cur_rw = rw; cur_alu = alu; cur_mld = mld;
        cur_src[0] = s0; cur_src[1] = s1; cur_rf[0] = rf0; cur_rf[1] = rf1;
        apply_cur();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        next_cycle();
        rst = 1'b0;
    endtask

    // Directed vectors: one row per cycle, expectations derived by hand
    typedef struct {
        bit          v, rg, ld;
        logic [4:0]  rw;
        logic [31:0] alu;
        logic [4:0]  s0, s1;
        logic [31:0] rf0, rf1, mld;
        bit          chk;
        logic [31:0] op0, op1;
        logic [1:0]  hit;
        bit          st, we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    function automatic vec_t mk(int v, int rg, int ld, int rw, int alu, int s0, int s1,
                                int rf0, int rf1, int mld, int chk, int op0, int op1,
                                int hit, int st, int we, int wa, int wd);
        vec_t r;
        r.v = v[0]; r.rg = rg[0]; r.ld = ld[0]; r.rw = 5'(rw); r.alu = 32'(alu);
        r.s0 = 5'(s0); r.s1 = 5'(s1); r.rf0 = 32'(rf0); r.rf1 = 32'(rf1); r.mld = 32'(mld);
        r.chk = chk[0]; r.op0 = 32'(op0); r.op1 = 32'(op1); r.hit = 2'(hit);
        r.st = st[0]; r.we = we[0]; r.wa = 5'(wa); r.wd = 32'(wd);
        return r;
    endfunction

    // Age-based reference: hist[a] is the instruction admitted a cycles ago
    typedef struct {
        bit          valid, rg, ld;
        logic [4:0]  rw;
        logic [31:0] val;
    } rec_t;

    rec_t        hist [1:DEPTH];
    bit          m_stall;
    bit          m_hit  [NSRC];
    bit          m_pend [NSRC];
    logic [31:0] m_op   [NSRC];

    task automatic model_clear();
        for (int a = 1; a <= DEPTH; a++) hist[a] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'd0};
    endtask

    task automatic model_eval();
        bit any_pend;
        any_pend = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            bit found;
            found     = 1'b0;
            m_op[i]   = cur_rf[i];
            m_hit[i]  = 1'b0;
            m_pend[i] = 1'b0;
            for (int a = 1; a <= DEPTH; a++) begin
                if (!found && hist[a].valid && hist[a].rg && cur_src[i] != 0 &&
                    hist[a].rw == cur_src[i]) begin
                    found = 1'b1;
                    if (!hist[a].ld || a > LOAD_STAGE) begin
                        m_op[i]  = hist[a].val;
                        m_hit[i] = 1'b1;
                    end else begin
                        m_pend[i] = 1'b1;
                    end
                end
            end
            any_pend |= m_pend[i];
        end
        m_stall = cur_v && any_pend;
    endtask

    task automatic model_edge();
        if (hist[LOAD_STAGE].valid && hist[LOAD_STAGE].ld) hist[LOAD_STAGE].val = cur_mld;
        for (int a = DEPTH; a >= 2; a--) hist[a] = hist[a-1];
        if (cur_v && !m_stall) hist[1] = '{1'b1, cur_rg, cur_ld, cur_rw, cur_alu};
        else                   hist[1] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'd0};
    endtask

    vec_t vecs [$];

    initial begin
        rst = 1'b1;
        set_in(1, 1, 0, 5'd1, 32'h0, 5'd3, 5'd4, 32'hAAA0, 32'hBBB0, 32'h0);
        #1;
        check("rst_stall",   bus.stall, 0);
        check("rst_hit",     bus.ex_fwd_hit, 0);
        check("rst_opnd0",   bus.ex_opnd[31:0], 32'hAAA0);
        check("rst_opnd1",   bus.ex_opnd[63:32], 32'hBBB0);
        check("rst_wb_we",   bus.wb_we, 0);
        check("rst_wb_addr", bus.wb_addr, 0);
        check("rst_wb_data", bus.wb_data, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        rst = 1'b0;

        //          v rg ld rw  alu         s0 s1 rf0     rf1     mld          chk op0          op1          hit st we wa wd
        vecs.push_back(mk(1,1,0, 3, 'h10,       1, 2, 'h100, 'h200, 0,           1, 'h100,       'h200,       0, 0, 0, 0, 0));
        vecs.push_back(mk(1,1,0, 4, 'h7,        3, 5, 'h300, 'h500, 0,           1, 'h10,        'h500,       1, 0, 0, 0, 0));
        vecs.push_back(mk(1,1,1, 6, 'h999,      3, 4, 'h300, 'h400, 0,           1, 'h10,        'h7,         3, 0, 1, 3, 'h10));
        vecs.push_back(mk(1,1,0, 7, 'h77,       6, 6, 'h600, 'h600, 'hDEADBEEF,  0, 0,           0,           0, 1, 1, 4, 'h7));
        vecs.push_back(mk(1,1,0, 7, 'h77,       6, 6, 'h600, 'h600, 0,           1, 'hDEADBEEF,  'hDEADBEEF,  3, 0, 1, 6, 'hDEADBEEF));
        vecs.push_back(mk(1,1,0, 8, 'h1,        0, 7, 'h11,  'h700, 0,           1, 'h11,        'h77,        2, 0, 0, 0, 0));
        vecs.push_back(mk(1,1,0, 8, 'h2,        0, 0, 'h11,  'h22,  0,           1, 'h11,        'h22,        0, 0, 1, 7, 'h77));
        vecs.push_back(mk(1,1,0, 9, 'h99,       8, 8, 'h800, 'h800, 0,           1, 'h2,         'h2,         3, 0, 1, 8, 'h1));
        vecs.push_back(mk(1,1,0, 0, 'h55,       9, 1, 'h900, 'h111, 0,           1, 'h99,        'h111,       1, 0, 1, 8, 'h2));
        vecs.push_back(mk(1,0,0, 0, 0,          0, 0, 'hAB,  'hCD,  0,           1, 'hAB,        'hCD,        0, 0, 1, 9, 'h99));
        vecs.push_back(mk(0,0,0, 0, 0,          0, 0, 'hAB,  'hCD,  0,           1, 'hAB,        'hCD,        0, 0, 0, 0, 0));
        vecs.push_back(mk(1,1,1, 10, 0,         0, 0, 'h1,   'h2,   0,           1, 'h1,         'h2,         0, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0, 0, 0,          10, 0, 'hA,  'hB,   'h1234,      0, 0,           0,           0, 0, 0, 0, 0));
        vecs.push_back(mk(1,0,0, 0, 0,          10, 0, 'hA,  'hB,   0,           1, 'h1234,      'hB,         1, 0, 1, 10, 'h1234));

        foreach (vecs[k]) begin
            vec_t r;
            r = vecs[k];
            set_in(r.v, r.rg, r.ld, r.rw, r.alu, r.s0, r.s1, r.rf0, r.rf1, r.mld);
            #3;
            check($sformatf("vec%0d_stall", k), bus.stall, r.st);
            check($sformatf("vec%0d_wb_we", k), bus.wb_we, r.we);
            if (r.chk) begin
                check($sformatf("vec%0d_opnd0", k), bus.ex_opnd[31:0], r.op0);
                check($sformatf("vec%0d_opnd1", k), bus.ex_opnd[63:32], r.op1);
                check($sformatf("vec%0d_hit", k), bus.ex_fwd_hit, r.hit);
            end
            if (r.we) begin
                check($sformatf("vec%0d_wb_addr", k), bus.wb_addr, r.wa);
                check($sformatf("vec%0d_wb_data", k), bus.wb_data, r.wd);
            end
            next_cycle();
        end

        // Reset while a load sits in stage 1: it must never reach writeback
        set_in(1, 1, 1, 5'd11, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        next_cycle();
        set_in(1, 1, 0, 5'd12, 32'h0, 5'd11, 5'd11, 32'hB0, 32'hB1, 32'h5555);
        #1;
        check("mid_pre_stall", bus.stall, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_stall", bus.stall, 0);
        check("mid_rst_hit",   bus.ex_fwd_hit, 0);
        check("mid_rst_opnd0", bus.ex_opnd[31:0], 32'hB0);
        check("mid_rst_wb_we", bus.wb_we, 0);
        next_cycle();
        rst = 1'b0;
        set_in(1, 0, 0, 5'd0, 32'h0, 5'd11, 5'd11, 32'hC0, 32'hC1, 32'h6666);
        #1;
        check("post_rst_stall", bus.stall, 0);
        check("post_rst_opnd1", bus.ex_opnd[63:32], 32'hC1);
        for (int c = 0; c < DEPTH + 2; c++) begin
            next_cycle();
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7777);
            #1;
            check($sformatf("post_rst_wb_we%0d", c), bus.wb_we, 0);
        end

`ifdef EX_FWD_STALL_CNT_EN
        do_reset();
        #1;
        check("stall_cnt_rst", stall_cnt, 0);
        for (int p = 0; p < 3; p++) begin
            set_in(1, 1, 1, 5'(13 + p), 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
            next_cycle();
            set_in(1, 1, 0, 5'd20, 32'h1, 5'(13 + p), 5'd0, 32'h0, 32'h0, 32'h100 + 32'(p));
            next_cycle();
            next_cycle();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("stall_cnt_3", stall_cnt, 3);
`endif

        // Random traffic against the reference model
        do_reset();
        model_clear();
        m_stall = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!m_stall) begin
                cur_v   = ($urandom_range(0, 9) < 8);
                cur_rg  = ($urandom_range(0, 5) != 0);
                cur_ld  = ($urandom_range(0, 2) == 0);
                cur_rw  = 5'($urandom_range(0, 3));
                cur_alu = $urandom;
                for (int i = 0; i < NSRC; i++) begin
                    cur_src[i] = 5'($urandom_range(0, 3));
                    cur_rf[i]  = $urandom;
                end
            end
            cur_mld = $urandom;
            apply_cur();
            model_eval();
            #3;
            check("rnd_stall", bus.stall, m_stall);
            for (int i = 0; i < NSRC; i++) begin
                if (!m_pend[i]) begin
                    check($sformatf("rnd_hit%0d", i), bus.ex_fwd_hit[i], m_hit[i]);
                    check($sformatf("rnd_opnd%0d", i), bus.ex_opnd[i*DATA_W +: DATA_W], m_op[i]);
                end
            end
            begin
                bit e_we;
                e_we = hist[DEPTH].valid && hist[DEPTH].rg && hist[DEPTH].rw != 0;
                check("rnd_wb_we", bus.wb_we, e_we);
                if (e_we) begin
                    check("rnd_wb_addr", bus.wb_addr, hist[DEPTH].rw);
                    check("rnd_wb_data", bus.wb_data, hist[DEPTH].val);
                end
            end
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
